mem_indirect_master: RTL

MEM_INDIRECT_MASTER -- requirements
Module: mem_indirect_master

---
 rtl/mem_indirect_pkg.sv | 17 +
 rtl/mem_indirect_master.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_indirect_pkg.sv
// Shared definitions for the indirect memory access protocol: register map
// of the mem_if target and the operation codes written to its OP register.
// Used by the initiator (mem_indirect_master) and by any responder.
package mem_indirect_pkg;

  localparam int unsigned REG_OP            = 3;
  localparam int unsigned REG_INDIRECT_ADDR = 4;
  localparam int unsigned REG_INDIRECT_DATA = 5;
  localparam int unsigned REG_RDDATA        = 6;

  typedef enum logic [1:0] {
    OPC_NOP = 2'b00,
    OPC_RD  = 2'b01,
    OPC_WR  = 2'b10
  } op_t;

endpackage

// File: rtl/mem_indirect_master.sv
// Indirect memory access initiator. Turns a single command (read or write of
// one indirect address) into a sequence of register accesses on mem_if:
// INDIRECT_ADDR / INDIRECT_DATA / OP writes, then an RDDATA read for reads.
//
// Ports
//   clk_i, arstn_i        clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake (ready only in IDLE)
//   cmd_write_i           1 = write, 0 = read
//   cmd_addr_i            indirect address
//   cmd_wdata_i           write data
//   rsp_valid_o           one-cycle completion pulse
//   rsp_rdata_o           read data (0 for writes / timeout), held to next rsp
//   rsp_error_o           read timeout flag, held to next rsp
//   mem_wr_o, mem_rd_o    register bus strobes (never both high)
//   mem_addr_o,mem_data_o register address / write data (0 when idle)
//   mem_rddata_i          register read data
//   mem_rddatavalid_i     read data qualifier (only looked at in R_DATA)
module mem_indirect_master
  import mem_indirect_pkg::*;
#(
  parameter int unsigned DWIDTH          = 8,
  parameter int unsigned AWIDTH          = 8,
  parameter int unsigned INDIRECT_AWIDTH = 8,
  parameter int unsigned TIMEOUT         = 15
) (
  input  logic                       clk_i,
  input  logic                       arstn_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_write_i,
  input  logic [INDIRECT_AWIDTH-1:0] cmd_addr_i,
  input  logic [DWIDTH-1:0]          cmd_wdata_i,
  output logic                       rsp_valid_o,
  output logic [DWIDTH-1:0]          rsp_rdata_o,
  output logic                       rsp_error_o,
  output logic                       mem_wr_o,
  output logic                       mem_rd_o,
  output logic [AWIDTH-1:0]          mem_addr_o,
  output logic [DWIDTH-1:0]          mem_data_o,
  input  logic [DWIDTH-1:0]          mem_rddata_i,
  input  logic                       mem_rddatavalid_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  // Each state name describes what the bus shows during that state; the bus
  // register for the next state is loaded on the transition into it.
  typedef enum logic [3:0] {
    INIT,
    IDLE,
    W_ADDR,
    W_DATA,
    W_OP,
    R_ADDR,
    R_OP,
    R_WAIT,
    R_REQ,
    R_DATA,
    OP_NOP,
    RESP
  } state_t;

  state_t            r_state;
  logic              r_ready;
  logic [DWIDTH-1:0] r_cmd_wdata;
  logic [CW-1:0]     r_cnt;
  logic [DWIDTH-1:0] r_cap_data;
  logic              r_cap_err;
  logic              r_rsp_valid;
  logic [DWIDTH-1:0] r_rsp_rdata;
  logic              r_rsp_error;
  logic              r_wr;
  logic              r_rd;
  logic [AWIDTH-1:0] r_bus_addr;
  logic [DWIDTH-1:0] r_bus_data;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state     <= INIT;
      r_ready     <= 1'b0;
      r_cmd_wdata <= '0;
      r_cnt       <= '0;
      r_cap_data  <= '0;
      r_cap_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_data  <= '0;
    end else begin
      // Bus and pulse defaults: idle bus with zero addr/data unless a state
      // below schedules an access for the next cycle.
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_data  <= '0;
      r_rsp_valid <= 1'b0;

      unique case (r_state)
        INIT: begin
          // Park the responder in NOP in case reset hit mid-operation.
          r_wr       <= 1'b1;
          r_bus_addr <= AWIDTH'(REG_OP);
          r_bus_data <= DWIDTH'(OPC_NOP);
          r_state    <= IDLE;
        end
        IDLE: begin
          if (r_ready && cmd_valid_i) begin
            r_ready     <= 1'b0;
            r_cmd_wdata <= cmd_wdata_i;
            r_wr        <= 1'b1;
            r_bus_addr  <= AWIDTH'(REG_INDIRECT_ADDR);
            r_bus_data  <= DWIDTH'(cmd_addr_i);
            r_state     <= cmd_write_i ? W_ADDR : R_ADDR;
          end else begin
            r_ready <= 1'b1;
          end
        end
        W_ADDR: begin
          r_wr       <= 1'b1;
          r_bus_addr <= AWIDTH'(REG_INDIRECT_DATA);
          r_bus_data <= r_cmd_wdata;
          r_state    <= W_DATA;
        end
        W_DATA: begin
          r_wr       <= 1'b1;
          r_bus_addr <= AWIDTH'(REG_OP);
          r_bus_data <= DWIDTH'(OPC_WR);
          r_state    <= W_OP;
        end
        W_OP: begin
          r_wr       <= 1'b1;
          r_bus_addr <= AWIDTH'(REG_OP);
          r_bus_data <= DWIDTH'(OPC_NOP);
          r_cap_data <= '0;
          r_cap_err  <= 1'b0;
          r_state    <= OP_NOP;
        end
        R_ADDR: begin
          r_wr       <= 1'b1;
          r_bus_addr <= AWIDTH'(REG_OP);
          r_bus_data <= DWIDTH'(OPC_RD);
          r_state    <= R_OP;
        end
        R_OP: begin
          r_state <= R_WAIT;
        end
        R_WAIT: begin
          r_rd       <= 1'b1;
          r_bus_addr <= AWIDTH'(REG_RDDATA);
          r_state    <= R_REQ;
        end
        R_REQ: begin
          r_cnt   <= CW'(1);
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (mem_rddatavalid_i || (r_cnt == CW'(TIMEOUT))) begin
            r_cap_data <= mem_rddatavalid_i ? mem_rddata_i : '0;
            r_cap_err  <= !mem_rddatavalid_i;
            r_cnt      <= '0;
            r_wr       <= 1'b1;
            r_bus_addr <= AWIDTH'(REG_OP);
            r_bus_data <= DWIDTH'(OPC_NOP);
            r_state    <= OP_NOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        OP_NOP: begin
          // Response fields change only here so they hold between responses.
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= r_cap_data;
          r_rsp_error <= r_cap_err;
          r_state     <= RESP;
        end
        RESP: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

  assign cmd_ready_o = r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_error_o = r_rsp_error;
  assign mem_wr_o    = r_wr;
  assign mem_rd_o    = r_rd;
  assign mem_addr_o  = r_bus_addr;
  assign mem_data_o  = r_bus_data;

endmodule
